// File: rtl/pr_arbiter_n.sv
// Registered N-channel priority resolver (IRR/ISR, rotation, EOI, SMM/SFNM); PR_POLL_EN adds poll/poll_word.
// Latency: irr/isr update 1 cycle after inputs; int_req/int_id follow the new state 1 cycle later.
// Backpressure: int_req is held until ack (or poll); an ack with no pending request only pulses spurious.
module pr_arbiter_n #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               level_trigger,
    input  logic [NUM_IRQ-1:0] int_mask,
    input  logic               special_mask_mode,
    input  logic               special_fully_nested,
    input  logic               auto_eoi,
    input  logic               auto_rotate,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    input  logic               ack,
    output logic               spurious,
    input  logic               eoi,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               eoi_rotate,
    input  logic               set_priority,
    input  logic [ID_W-1:0]    priority_base,
`ifdef PR_POLL_EN
    input  logic               poll,
    output logic [ID_W:0]      poll_word,
`endif
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [ID_W-1:0]    lowest_priority
);

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] blk;
    logic [NUM_IRQ-1:0] irr_nxt;
    logic [NUM_IRQ-1:0] isr_nxt;
    logic [ID_W-1:0]    lp_nxt;
    logic [ID_W-1:0]    scan_ch;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    isr_top_id;
    logic [ID_W-1:0]    eoi_clr_id;
    logic               win_vld;
    logic               eoi_clr;
    logic               take;
    int                 cand_rank;
    int                 blk_rank;
    int                 isr_rank;

    // Channel sitting at a given rank (0 = highest) for the current rotation; wrap is explicit mod N.
    function automatic logic [ID_W-1:0] chan_at(input logic [ID_W-1:0] lp, input int rank);
        int c;
        c = int'(lp) + 1 + rank;
        if (c >= NUM_IRQ) c = c - NUM_IRQ;
        return ID_W'(c);
    endfunction

`ifdef PR_POLL_EN
    assign take = (ack | poll) & int_req;
`else
    assign take = ack & int_req;
`endif

    assign cand = irr & ~int_mask;
    assign blk  = special_mask_mode ? (isr & ~int_mask) : isr;

    // Scan from lowest rank upward so the last hit is the highest-priority one.
    always_comb begin
        cand_rank  = NUM_IRQ;
        blk_rank   = NUM_IRQ;
        isr_rank   = NUM_IRQ;
        win_id     = '0;
        isr_top_id = '0;
        scan_ch    = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            scan_ch = chan_at(lowest_priority, k);
            if (cand[scan_ch]) begin
                cand_rank = k;
                win_id    = scan_ch;
            end
            if (blk[scan_ch]) blk_rank = k;
            if (isr[scan_ch]) begin
                isr_rank   = k;
                isr_top_id = scan_ch;
            end
        end
        win_vld = (cand_rank < NUM_IRQ) &&
                  ((cand_rank < blk_rank) ||
                   (special_fully_nested && (cand_rank == blk_rank)));
    end

    // Only a bit that is actually in service counts as cleared, which gates eoi_rotate.
    always_comb begin
        eoi_clr    = 1'b0;
        eoi_clr_id = '0;
        if (eoi) begin
            if (eoi_specific) begin
                if ((int'(eoi_id) < NUM_IRQ) && isr[eoi_id]) begin
                    eoi_clr    = 1'b1;
                    eoi_clr_id = eoi_id;
                end
            end else if (isr_rank < NUM_IRQ) begin
                eoi_clr    = 1'b1;
                eoi_clr_id = isr_top_id;
            end
        end
    end

    always_comb begin
        if (level_trigger) begin
            irr_nxt = irq_in;
        end else begin
            irr_nxt = irr & ~(irq_prev & ~irq_in);
            if (take) irr_nxt[int_id] = 1'b0;
            irr_nxt = irr_nxt | (irq_in & ~irq_prev);
        end
    end

    // EOI clears before ack sets, so a same-bit ack re-enters service.
    always_comb begin
        isr_nxt = isr;
        if (eoi_clr) isr_nxt[eoi_clr_id] = 1'b0;
        if (take && !auto_eoi) isr_nxt[int_id] = 1'b1;
    end

    always_comb begin
        lp_nxt = lowest_priority;
        if (eoi_clr && eoi_rotate) lp_nxt = eoi_clr_id;
        if (take && auto_eoi && auto_rotate) lp_nxt = int_id;
        if (set_priority && (int'(priority_base) < NUM_IRQ)) lp_nxt = priority_base;
    end

    // int_req drops for the cycle after an ack so the stale winner cannot be taken twice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev        <= '0;
            irr             <= '0;
            isr             <= '0;
            int_req         <= 1'b0;
            int_id          <= '0;
            spurious        <= 1'b0;
            lowest_priority <= ID_W'(NUM_IRQ - 1);
        end else begin
            irq_prev        <= irq_in;
            irr             <= irr_nxt;
            isr             <= isr_nxt;
            spurious        <= ack & ~int_req;
            lowest_priority <= lp_nxt;
            if (take) begin
                int_req <= 1'b0;
            end else begin
                int_req <= win_vld;
                if (win_vld) int_id <= win_id;
            end
        end
    end

`ifdef PR_POLL_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            poll_word <= '0;
        end else if (poll) begin
            poll_word <= {int_req, int_id};
        end
    end
`endif

endmodule

// File: doc/pr_arbiter_n.md
Name: pr_arbiter_n

Overview:
Parametrised, registered successor to the combinational 8-level priority resolver. It holds the IRR and ISR state for NUM_IRQ channels and supports edge or level triggering, fixed or rotating priority, specific and non-specific EOI, auto-EOI, special mask and special fully nested modes. It presents one winning vector to the CPU-side control logic over a req/ack handshake. It sits between the IRQ pins / mask register and the INTA sequencer of the PIC.

Parameters:
NUM_IRQ, 8, channel count; legal range 2..32; need not be a power of two.
ID_W, $clog2(NUM_IRQ), width of channel ids.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  raw request lines, synchronous to clock
level_trigger  in  1  1 = level mode, 0 = rising-edge mode
int_mask  in  NUM_IRQ  1 = channel masked
special_mask_mode  in  1  masked ISR bits do not block lower-priority channels
special_fully_nested  in  1  in-service channel may be re-interrupted by the same level
auto_eoi  in  1  ack does not set ISR
auto_rotate  in  1  rotate on auto-EOI
int_req  out  1  pending interrupt available (registered)
int_id  out  ID_W  id of pending winner (registered)
ack  in  1  one-cycle acknowledge pulse
spurious  out  1  one-cycle pulse: ack arrived with int_req=0
eoi  in  1  one-cycle EOI command
eoi_specific  in  1  qualifies eoi: 1 = clear eoi_id, 0 = clear highest ISR
eoi_id  in  ID_W  target of specific EOI
eoi_rotate  in  1  qualifies eoi: lowest priority := cleared id
set_priority  in  1  one-cycle pulse: lowest priority := priority_base
priority_base  in  ID_W  new lowest-priority id
irr  out  NUM_IRQ  interrupt request register
isr  out  NUM_IRQ  in-service register
lowest_priority  out  ID_W  current lowest-priority id

Behaviour:
- Reset (async, reset_n=0): irr=0, isr=0, int_req=0, int_id=0, spurious=0, lowest_priority=NUM_IRQ-1 (channel 0 highest). The edge-detect history register is reset to 0.
- Priority order: the highest-priority channel is (lowest_priority+1) mod NUM_IRQ, and priority descends cyclically from it. All wraps use explicit mod NUM_IRQ arithmetic, never bit truncation.
- IRR, edge mode: bit sets on a 0→1 transition of irq_in versus the previous cycle. It clears on ack of that id, or when irq_in falls.
- IRR, level mode: irr follows irq_in, registered with one cycle of latency.
- Candidates: irr & ~int_mask.
- Blocking set: isr, or isr & ~int_mask when special_mask_mode=1.
- Winner: the highest-priority candidate ranked strictly above the highest-priority blocking bit.
  - With special_fully_nested, a candidate equal in level to the highest blocking bit also wins.
  - If the blocking set is empty, any candidate wins.
- int_req and int_id register the winner each cycle, so latency from an irr change to int_req is 1 cycle. int_id holds its last value while int_req=0.
- Ack with int_req=1, applied using the registered int_id:
  - irr[int_id] clears (edge mode).
  - isr[int_id] sets, unless auto_eoi=1.
  - If auto_eoi and auto_rotate are both 1, lowest_priority := int_id.
  - int_req is recomputed next cycle from the new state.
- Ack with int_req=0: spurious pulses for 1 cycle; no state changes.
- Non-specific EOI: clears the highest-priority set isr bit; no-op if isr=0.
- Specific EOI: clears isr[eoi_id]. eoi_id >= NUM_IRQ is ignored.
- EOI with eoi_rotate=1: lowest_priority := the cleared id. If nothing was cleared, lowest_priority is unchanged.
- Simultaneous events, all evaluated against pre-cycle state:
  - eoi and ack in the same cycle: eoi clears first, then ack sets, so a same-bit set wins.
  - A new edge on a channel being acked the same cycle leaves irr set.
  - set_priority beats any rotation in the same cycle.
  - priority_base >= NUM_IRQ is ignored.

Optional Feature:
PR_POLL_EN:
- Defined: adds port poll (in, 1) and poll_word (out, ID_W+1, registered).
- A poll pulse captures {int_req, int_id} into poll_word. If int_req=1, it performs exactly the ack state update; spurious is not raised.
- poll_word resets to 0.
- Not defined: neither port exists, and behaviour is as above.

Test Plan:
- Reset, then irq_in=0x05 rising edges, mask 0, NUM_IRQ=8 → irr=0x05 after 1 clk; int_req=1, int_id=0 the next clk.
- Ack; then a non-specific EOI with eoi_rotate=1 → isr=0x01 after the ack, then 0x00; lowest_priority=0; int_id=2 next.
- NUM_IRQ=5, set_priority with base=4, then irq 4 and 0 pending → winner id 0. Specific EOI with rotate after servicing id 2 → priority order 3,4,0,1,2.
- isr=0x04 in service, irq 2 re-raised with special_fully_nested=1 → int_req=1, int_id=2. With it 0 → int_req=0.
- ack while int_req=0 → spurious high exactly 1 cycle; irr and isr unchanged.
- Assert reset_n low mid-service (isr=0x10, int_req=1) → all outputs at reset values immediately, without waiting for a clock edge.
